// File: rtl/gate_selftest_pkg.sv
// Shared types, constants and the golden gate model for the gate library self-test checker.
package gate_selftest_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   // Right-shifting Galois mask for x^64+x^63+x^61+x^60+1
   localparam logic [63:0] LfsrPoly = 64'hD800_0000_0000_0000;

   localparam int unsigned RotIn2 = 17;
   localparam int unsigned RotIn3 = 41;

   localparam int unsigned GateInv   = 0;
   localparam int unsigned GateNand2 = 1;
   localparam int unsigned GateMux2  = 2;

   typedef struct packed {
      logic [63:0] inv;
      logic [63:0] nand2;
      logic [63:0] mux2;
   } golden_t;

   function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
      return (x << n) | (x >> (64 - n));
   endfunction

   function automatic golden_t golden(input logic [63:0] in1, input logic [63:0] in2,
                                      input logic [63:0] in3);
      golden_t g;
      g.inv   = ~in1;
      g.nand2 = ~(in1 & in2);
      g.mux2  = in3[0] ? in2 : in1;
      return g;
   endfunction

endpackage

// File: rtl/gate_selftest_lfsr.sv
// 64-bit Galois LFSR with seed load and advance enable; exposes the next-state value.
module gate_selftest_lfsr
   import gate_selftest_pkg::*;
#(
   parameter logic [63:0] SEED = 64'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        adv_i,
   output logic [63:0] next_o
);
   // An all-zero state would lock up the LFSR
   localparam logic [63:0] SeedNz = (SEED == 64'h0) ? 64'h1 : SEED;

   logic [63:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SeedNz;
      end else if (adv_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrPoly : 64'h0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SeedNz;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign next_o = lfsr_d;

endmodule

// File: rtl/gate_selftest_checker.sv
// Self-test stimulus generator and response checker for the INV/NAND2/MUX2 gate library.
module gate_selftest_checker
   import gate_selftest_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [63:0] SEED        = 64'h1,
   parameter int unsigned DUT_LAT     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] stim_in1,
   output logic [WIDTH-1:0] stim_in2,
   output logic [WIDTH-1:0] stim_in3,
   input  logic [WIDTH-1:0] dut_inv,
   input  logic [WIDTH-1:0] dut_nand2,
   input  logic [WIDTH-1:0] dut_mux2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [20:0]      vec_count,
   output logic [15:0]      err_count,
   output logic [20:0]      first_err_idx,
   output logic [2:0]       first_err_gate
);
   localparam logic [20:0] LastIdx = 21'(NUM_VECTORS - 1);

   typedef struct packed {
      logic             valid;
      logic [20:0]      idx;
      logic [WIDTH-1:0] inv;
      logic [WIDTH-1:0] nand2;
      logic [WIDTH-1:0] mux2;
   } exp_t;

   state_e           state_q, state_d;
   logic [20:0]      issue_idx_q, issue_idx_d;
   logic [WIDTH-1:0] stim1_q, stim1_d, stim2_q, stim2_d, stim3_q, stim3_d;
   logic [20:0]      vec_count_q, vec_count_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [20:0]      first_idx_q, first_idx_d;
   logic [2:0]       first_gate_q, first_gate_d;

   logic        start_run, lfsr_adv;
   logic [63:0] lfsr_next, rot2, rot3;
   golden_t     gold;
   exp_t        exp_in, cmp;
   logic [2:0]  mism;

   assign start_run = start && (state_q == StIdle || state_q == StDone);
   assign lfsr_adv  = (state_q == StRun) && (issue_idx_q != LastIdx);

   gate_selftest_lfsr #(
      .SEED(SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load_i(start_run),
      .adv_i (lfsr_adv),
      .next_o(lfsr_next)
   );

   assign rot2 = rotl64(lfsr_next, RotIn2);
   assign rot3 = rotl64(lfsr_next, RotIn3);

   // Stimulus registers take the LFSR next-state so vector k is visible during RUN cycle k
   always_comb begin
      stim1_d = stim1_q;
      stim2_d = stim2_q;
      stim3_d = stim3_q;
      if (start_run || lfsr_adv) begin
         stim1_d = lfsr_next[WIDTH-1:0];
         stim2_d = rot2[WIDTH-1:0];
         stim3_d = rot3[WIDTH-1:0];
      end
   end

   assign gold = golden(64'(stim1_q), 64'(stim2_q), 64'(stim3_q));

   always_comb begin
      exp_in.valid = (state_q == StRun);
      exp_in.idx   = issue_idx_q;
      exp_in.inv   = gold.inv[WIDTH-1:0];
      exp_in.nand2 = gold.nand2[WIDTH-1:0];
      exp_in.mux2  = gold.mux2[WIDTH-1:0];
   end

   // Expected values are delayed to line up with the gate output latency
   if (DUT_LAT == 0) begin : g_direct
      assign cmp = exp_in;
   end else begin : g_pipe
      exp_t pipe_q [DUT_LAT];
      always_ff @(posedge clk) begin
         if (rst || start_run) begin
            for (int i = 0; i < DUT_LAT; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= exp_in;
            for (int i = 1; i < DUT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign cmp = pipe_q[DUT_LAT-1];
   end

   always_comb begin
      mism            = '0;
      mism[GateInv]   = (dut_inv != cmp.inv);
      mism[GateNand2] = (dut_nand2 != cmp.nand2);
      mism[GateMux2]  = (dut_mux2 != cmp.mux2);
   end

   always_comb begin
      state_d     = state_q;
      issue_idx_d = issue_idx_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StRun;
               issue_idx_d = '0;
            end
         end
         StRun: begin
            if (issue_idx_q == LastIdx) begin
               state_d = (DUT_LAT == 0) ? StDone : StDrain;
            end else begin
               issue_idx_d = issue_idx_q + 21'd1;
            end
         end
         StDrain: begin
            if (cmp.valid && cmp.idx == LastIdx) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      vec_count_d  = vec_count_q;
      err_count_d  = err_count_q;
      first_idx_d  = first_idx_q;
      first_gate_d = first_gate_q;
      if (start_run) begin
         vec_count_d  = '0;
         err_count_d  = '0;
         first_idx_d  = '0;
         first_gate_d = '0;
      end else if (cmp.valid) begin
         vec_count_d = vec_count_q + 21'd1;
         if (|mism) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            // err_count saturates rather than wraps, so zero means no error seen yet
            if (err_count_q == 16'h0) begin
               first_idx_d  = cmp.idx;
               first_gate_d = mism;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         issue_idx_q  <= '0;
         stim1_q      <= '0;
         stim2_q      <= '0;
         stim3_q      <= '0;
         vec_count_q  <= '0;
         err_count_q  <= '0;
         first_idx_q  <= '0;
         first_gate_q <= '0;
      end else begin
         state_q      <= state_d;
         issue_idx_q  <= issue_idx_d;
         stim1_q      <= stim1_d;
         stim2_q      <= stim2_d;
         stim3_q      <= stim3_d;
         vec_count_q  <= vec_count_d;
         err_count_q  <= err_count_d;
         first_idx_q  <= first_idx_d;
         first_gate_q <= first_gate_d;
      end
   end

   assign stim_in1       = stim1_q;
   assign stim_in2       = stim2_q;
   assign stim_in3       = stim3_q;
   assign busy           = (state_q == StRun) || (state_q == StDrain);
   assign done           = (state_q == StDone);
   assign pass           = (state_q == StDone) && (err_count_q == 16'h0);
   assign vec_count      = vec_count_q;
   assign err_count      = err_count_q;
   assign first_err_idx  = first_idx_q;
   assign first_err_gate = first_gate_q;

endmodule

// File: tb/tb_gate_selftest_checker.sv
// Bench for gate_selftest_checker: modelled gates with injectable faults, checked against a
// reference built from the LFSR/golden-model definition.
module tb_gate_selftest_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- instance A: 64-bit, 16 vectors, SEED=1, DUT_LAT=0 ----------------
   logic        start_a = 1'b0;
   logic [63:0] a_s1, a_s2, a_s3, a_inv, a_nand, a_mux;
   logic        a_busy, a_done, a_pass;
   logic [20:0] a_vec, a_idx;
   logic [15:0] a_err;
   logic [2:0]  a_gate;
   int          a_mode = 0;
   int          a_fgate = 0;
   int          a_fbit = 0;
   logic [63:0] a_fv = '0;
   logic        a_hit;
   logic [63:0] a_fmask;

   assign a_hit   = (a_mode == 1) && (a_s1 == a_fv);
   assign a_fmask = 64'h1 << a_fbit;
   assign a_inv   = ~a_s1 ^ ((a_hit && a_fgate == 0) ? a_fmask : 64'h0);
   assign a_nand  = ~(a_s1 & a_s2) ^ ((a_hit && a_fgate == 1) ? a_fmask : 64'h0);
   assign a_mux   = ((a_mode == 2) ? a_s1 : (a_s3[0] ? a_s2 : a_s1))
                    ^ ((a_hit && a_fgate == 2) ? a_fmask : 64'h0);

   gate_selftest_checker #(
      .WIDTH(64), .NUM_VECTORS(16), .SEED(64'h1), .DUT_LAT(0)
   ) u_a (
      .clk(clk), .rst(rst), .start(start_a),
      .stim_in1(a_s1), .stim_in2(a_s2), .stim_in3(a_s3),
      .dut_inv(a_inv), .dut_nand2(a_nand), .dut_mux2(a_mux),
      .busy(a_busy), .done(a_done), .pass(a_pass), .vec_count(a_vec), .err_count(a_err),
      .first_err_idx(a_idx), .first_err_gate(a_gate)
   );

   // ---------------- instance B: 8-bit, 65540 vectors, INV always wrong ----------------
   logic        start_b = 1'b0;
   logic [7:0]  b_s1, b_s2, b_s3, b_inv, b_nand, b_mux;
   logic        b_busy, b_done, b_pass;
   logic [20:0] b_vec, b_idx;
   logic [15:0] b_err;
   logic [2:0]  b_gate;

   assign b_inv  = b_s1;
   assign b_nand = ~(b_s1 & b_s2);
   assign b_mux  = b_s3[0] ? b_s2 : b_s1;

   gate_selftest_checker #(
      .WIDTH(8), .NUM_VECTORS(65540), .SEED(64'h1), .DUT_LAT(0)
   ) u_b (
      .clk(clk), .rst(rst), .start(start_b),
      .stim_in1(b_s1), .stim_in2(b_s2), .stim_in3(b_s3),
      .dut_inv(b_inv), .dut_nand2(b_nand), .dut_mux2(b_mux),
      .busy(b_busy), .done(b_done), .pass(b_pass), .vec_count(b_vec), .err_count(b_err),
      .first_err_idx(b_idx), .first_err_gate(b_gate)
   );

   // ------- instances C (DUT_LAT=2) and D (DUT_LAT=0), both with 2-stage registered gates -------
   logic        start_cd = 1'b0;
   logic [15:0] c_s1, c_s2, c_s3, c_inv, c_nand, c_mux, c_p_inv, c_p_nand, c_p_mux;
   logic [15:0] d_s1, d_s2, d_s3, d_inv, d_nand, d_mux, d_p_inv, d_p_nand, d_p_mux;
   logic        c_busy, c_done, c_pass, d_busy, d_done, d_pass;
   logic [20:0] c_vec, c_idx, d_vec, d_idx;
   logic [15:0] c_err, d_err;
   logic [2:0]  c_gate, d_gate;

   always_ff @(posedge clk) begin
      c_p_inv  <= ~c_s1;
      c_p_nand <= ~(c_s1 & c_s2);
      c_p_mux  <= c_s3[0] ? c_s2 : c_s1;
      c_inv    <= c_p_inv;
      c_nand   <= c_p_nand;
      c_mux    <= c_p_mux;
      d_p_inv  <= ~d_s1;
      d_p_nand <= ~(d_s1 & d_s2);
      d_p_mux  <= d_s3[0] ? d_s2 : d_s1;
      d_inv    <= d_p_inv;
      d_nand   <= d_p_nand;
      d_mux    <= d_p_mux;
   end

   gate_selftest_checker #(
      .WIDTH(16), .NUM_VECTORS(32), .SEED(64'h0), .DUT_LAT(2)
   ) u_c (
      .clk(clk), .rst(rst), .start(start_cd),
      .stim_in1(c_s1), .stim_in2(c_s2), .stim_in3(c_s3),
      .dut_inv(c_inv), .dut_nand2(c_nand), .dut_mux2(c_mux),
      .busy(c_busy), .done(c_done), .pass(c_pass), .vec_count(c_vec), .err_count(c_err),
      .first_err_idx(c_idx), .first_err_gate(c_gate)
   );

   gate_selftest_checker #(
      .WIDTH(16), .NUM_VECTORS(32), .SEED(64'h0), .DUT_LAT(0)
   ) u_d (
      .clk(clk), .rst(rst), .start(start_cd),
      .stim_in1(d_s1), .stim_in2(d_s2), .stim_in3(d_s3),
      .dut_inv(d_inv), .dut_nand2(d_nand), .dut_mux2(d_mux),
      .busy(d_busy), .done(d_done), .pass(d_pass), .vec_count(d_vec), .err_count(d_err),
      .first_err_idx(d_idx), .first_err_gate(d_gate)
   );

   // ---------------- reference model ----------------
   logic [63:0] m1 [16];
   logic [63:0] m2 [16];
   logic [63:0] m3 [16];

   // Galois step of x^64+x^63+x^61+x^60+1 (taps 64,63,61,60 -> bits 63,62,60,59)
   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      logic [63:0] taps;
      taps = (64'h1 << 63) | (64'h1 << 62) | (64'h1 << 60) | (64'h1 << 59);
      return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   task automatic build_model();
      logic [63:0] s;
      s = 64'h1;
      for (int k = 0; k < 16; k++) begin
         m1[k] = s;
         m2[k] = rotl(s, 17);
         m3[k] = rotl(s, 41);
         s = lfsr_step(s);
      end
   endtask

   // Expected outcome of a 16-vector run on instance A for a given fault scenario
   task automatic model_a(input int mode, input int fgate, input int fvec,
                          output int e_err, output int e_idx, output logic [2:0] e_gate);
      e_err  = 0;
      e_idx  = 0;
      e_gate = 3'b000;
      for (int k = 0; k < 16; k++) begin
         logic [2:0] f;
         f = 3'b000;
         if (mode == 1 && k == fvec) f[fgate] = 1'b1;
         if (mode == 2 && m3[k][0] && m1[k] != m2[k]) f[2] = 1'b1;
         if (f != 3'b000) begin
            if (e_err == 0) begin
               e_idx  = k;
               e_gate = f;
            end
            e_err++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_a(input string tag, input int pulse_at, input int mode, input int fgate,
                        input int fbit, input int fvec);
      int          c, e_err, e_idx;
      logic [2:0]  e_gate;
      a_mode  = mode;
      a_fgate = fgate;
      a_fbit  = fbit;
      a_fv    = m1[fvec];
      model_a(mode, fgate, fvec, e_err, e_idx, e_gate);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check({tag, "_in1_first"}, a_s1, 64'h1);
      check({tag, "_in2_first"}, a_s2, 64'h1 << 17);
      check({tag, "_in3_first"}, a_s3, m3[0]);
      c = 0;
      while (a_busy && c < 100) begin
         c++;
         start_a = (c == pulse_at);
         tick();
      end
      start_a = 1'b0;
      check({tag, "_busy_cycles"}, 64'(c), 64'd16);
      check({tag, "_done"}, 64'(a_done), 64'd1);
      check({tag, "_pass"}, 64'(a_pass), 64'(e_err == 0));
      check({tag, "_vec_count"}, 64'(a_vec), 64'd16);
      check({tag, "_err_count"}, 64'(a_err), 64'(e_err));
      check({tag, "_first_idx"}, 64'(a_idx), 64'(e_idx));
      check({tag, "_first_gate"}, 64'(a_gate), 64'(e_gate));
      check({tag, "_in1_held"}, a_s1, m1[15]);
   endtask

   initial begin
      int c;
      build_model();

      // Reset with start held high: nothing may begin
      start_a  = 1'b1;
      start_b  = 1'b1;
      start_cd = 1'b1;
      repeat (3) tick();
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_done", 64'(a_done), 64'd0);
      check("rst_pass", 64'(a_pass), 64'd0);
      check("rst_vec", 64'(a_vec), 64'd0);
      check("rst_err", 64'(a_err), 64'd0);
      check("rst_idx", 64'(a_idx), 64'd0);
      check("rst_gate", 64'(a_gate), 64'd0);
      check("rst_in1", a_s1, 64'd0);
      check("rst_in2", a_s2, 64'd0);
      check("rst_in3", a_s3, 64'd0);
      rst      = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      start_cd = 1'b0;
      repeat (2) tick();
      check("idle_a_busy", 64'(a_busy), 64'd0);
      check("idle_b_busy", 64'(b_busy), 64'd0);
      check("idle_c_busy", 64'(c_busy), 64'd0);

      run_a("good", 0, 0, 0, 0, 0);
      run_a("nand_b3_v5", 0, 1, 1, 3, 5);
      run_a("mux_sel_stuck", 0, 2, 0, 0, 0);
      for (int r = 0; r < 3; r++) begin
         run_a($sformatf("rand_fault%0d", r), 0, 1, int'($urandom_range(2, 0)),
               int'($urandom_range(63, 0)), int'($urandom_range(15, 0)));
      end

      // Reset at RUN cycle 7 of a faulted run, then a clean run with an ignored start pulse
      a_mode  = 1;
      a_fgate = 0;
      a_fbit  = 0;
      a_fv    = m1[2];
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 64'(a_busy), 64'd0);
      check("midrst_done", 64'(a_done), 64'd0);
      check("midrst_vec", 64'(a_vec), 64'd0);
      check("midrst_err", 64'(a_err), 64'd0);
      check("midrst_gate", 64'(a_gate), 64'd0);
      check("midrst_in1", a_s1, 64'd0);
      run_a("after_rst", 4, 0, 0, 0, 0);

      // Latency-2 registered gates: matched vs unmatched DUT_LAT
      start_cd = 1'b1;
      tick();
      start_cd = 1'b0;
      check("lat_seed0_in1", 64'(c_s1), 64'(m1[0][15:0]));
      check("lat_seed0_in3", 64'(c_s3), 64'(m3[0][15:0]));
      c = 0;
      while (c_busy && c < 200) begin
         c++;
         tick();
      end
      check("lat2_busy_cycles", 64'(c), 64'd34);
      check("lat2_pass", 64'(c_pass), 64'd1);
      check("lat2_vec", 64'(c_vec), 64'd32);
      check("lat2_err", 64'(c_err), 64'd0);
      check("lat0_done", 64'(d_done), 64'd1);
      check("lat0_vec", 64'(d_vec), 64'd32);
      check("lat0_err_nonzero", 64'(d_err != 16'h0), 64'd1);
      check("lat0_pass", 64'(d_pass), 64'd0);

      // Always-failing INV over 65540 vectors: counter saturates
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      c = 0;
      while (!b_done && c < 70000) begin
         c++;
         tick();
      end
      check("sat_done", 64'(b_done), 64'd1);
      check("sat_vec", 64'(b_vec), 64'd65540);
      check("sat_err", 64'(b_err), 64'hFFFF);
      check("sat_idx", 64'(b_idx), 64'd0);
      check("sat_gate", 64'(b_gate), 64'b001);
      check("sat_pass", 64'(b_pass), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
